// File: rtl/seq_detect_scan.sv
// Serial pattern detector sampled by a push-button strobe, with a saturating match
// counter and a time-multiplexed digit/select display of history, fill and count.
module seq_detect_scan #(
  parameter int unsigned         PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0]  PATTERN  = 4'b1100,
  parameter bit                  OVERLAP  = 1'b1,
  parameter int unsigned         HIST_W   = 4,
  parameter int unsigned         CNT_W    = 4,
  parameter int unsigned         SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  input  logic              sw,
  input  logic              clr,
  output logic              match,
  output logic [HIST_W-1:0] hist,
  output logic [CNT_W-1:0]  count,
  output logic [3:0]        D,
  output logic [2:0]        AN
);

  localparam int unsigned DIV_W     = $clog2(SCAN_DIV);
  localparam logic [2:0]  FULL      = 3'(PAT_LEN);
  localparam logic [2:0]  FILL_SLOT = 3'(HIST_W);
  localparam logic [2:0]  LAST_SLOT = 3'(HIST_W + 1);

  logic               b1, b2, b3, sample;
  logic [PAT_LEN-1:0] window, window_d;
  logic [PAT_LEN:0]   window_sh;
  logic [HIST_W-1:0]  hist_d;
  logic [HIST_W:0]    hist_sh;
  logic [2:0]         fill, fill_inc, fill_d;
  logic [CNT_W-1:0]   count_d;
  logic               hit;

  logic [DIV_W-1:0]   div;
  logic [2:0]         slot, slot_d;
  logic [3:0]         d_d;
  logic [7:0]         hist_pad;
  logic               tick;

  assign sample    = b2 & ~b3;
  assign window_sh = {window, sw};
  assign hist_sh   = {hist, sw};
  assign fill_inc  = (fill == FULL) ? fill : fill + 3'd1;

  // Match is judged on the post-shift window so it lines up with the sample itself.
  always_comb begin
    window_d = window;
    hist_d   = hist;
    fill_d   = fill;
    count_d  = count;
    hit      = 1'b0;
    if (clr) begin
      window_d = '0;
      hist_d   = '0;
      fill_d   = '0;
      count_d  = '0;
    end else if (sample) begin
      window_d = window_sh[PAT_LEN-1:0];
      hist_d   = hist_sh[HIST_W-1:0];
      hit      = (fill_inc == FULL) && (window_d == PATTERN);
      fill_d   = (hit && !OVERLAP) ? 3'd0 : fill_inc;
      if (hit && (count != '1)) begin
        count_d = count + 1'b1;
      end
    end
  end

  assign tick     = (div == DIV_W'(SCAN_DIV - 1));
  assign hist_pad = 8'(hist);

  always_comb begin
    slot_d = (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
    if (slot_d == FILL_SLOT) begin
      d_d = 4'hA + 4'(fill);
    end else if (slot_d == LAST_SLOT) begin
      d_d = 4'(count);
    end else begin
      d_d = {3'b000, hist_pad[slot_d]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b1     <= 1'b0;
      b2     <= 1'b0;
      b3     <= 1'b0;
      window <= '0;
      hist   <= '0;
      fill   <= '0;
      count  <= '0;
      match  <= 1'b0;
      div    <= '0;
      slot   <= '0;
      D      <= '0;
      AN     <= '0;
    end else begin
      b1     <= button;
      b2     <= b1;
      b3     <= b2;
      window <= window_d;
      hist   <= hist_d;
      fill   <= fill_d;
      count  <= count_d;
      match  <= hit;
      div    <= tick ? '0 : div + 1'b1;
      if (tick) begin
        slot <= slot_d;
        D    <= d_d;
        AN   <= slot_d;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_scan.sv
// Bench for seq_detect_scan: four parameter variants share one stimulus stream and are
// checked against a queue-based model of sampled bits.
module tb_seq_detect_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button = 1'b0;
  logic       sw = 1'b0;
  logic       clr = 1'b0;
  logic       m  [4];
  logic [3:0] h  [4];
  logic [3:0] c  [4];
  logic [3:0] d  [4];
  logic [2:0] an [4];
  logic [1:0] c_sat;

  assign c[3] = {2'b00, c_sat};

  always #5 clk = ~clk;

  seq_detect_scan #(.SCAN_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .button(button), .sw(sw), .clr(clr),
    .match(m[0]), .hist(h[0]), .count(c[0]), .D(d[0]), .AN(an[0])
  );
  seq_detect_scan #(.PATTERN(4'b1010), .OVERLAP(1'b1), .SCAN_DIV(4)) dut_ov (
    .clk(clk), .rst(rst), .button(button), .sw(sw), .clr(clr),
    .match(m[1]), .hist(h[1]), .count(c[1]), .D(d[1]), .AN(an[1])
  );
  seq_detect_scan #(.PATTERN(4'b1010), .OVERLAP(1'b0), .SCAN_DIV(4)) dut_no (
    .clk(clk), .rst(rst), .button(button), .sw(sw), .clr(clr),
    .match(m[2]), .hist(h[2]), .count(c[2]), .D(d[2]), .AN(an[2])
  );
  seq_detect_scan #(.CNT_W(2), .SCAN_DIV(4)) dut_sat (
    .clk(clk), .rst(rst), .button(button), .sw(sw), .clr(clr),
    .match(m[3]), .hist(h[3]), .count(c_sat), .D(d[3]), .AN(an[3])
  );

  int         checks = 0;
  int         errors = 0;
  logic [3:0] pat  [4];
  bit         ov   [4];
  int         cmax [4];
  bit         samp [$];
  int         since  [4];
  int         nmatch [4];
  bit         exp_m  [4];

  function automatic logic [3:0] model_hist();
    logic [3:0] r = 4'b0000;
    for (int j = 0; j < 4 && j < samp.size(); j++) r[2'(j)] = samp[samp.size() - 1 - j];
    return r;
  endfunction

  function automatic logic [3:0] model_count(input int k);
    return 4'(nmatch[k] < cmax[k] ? nmatch[k] : cmax[k]);
  endfunction

  function automatic logic [3:0] model_fill_digit(input int k);
    return 4'(10 + (since[k] < 4 ? since[k] : 4));
  endfunction

  task automatic model_clear();
    samp.delete();
    for (int k = 0; k < 4; k++) begin
      since[k] = 0; nmatch[k] = 0; exp_m[k] = 1'b0;
    end
  endtask

  // A match needs the last four samples to equal the pattern, all taken since the
  // last clear (or, without overlap, since the last match).
  task automatic model_sample(input bit b);
    samp.push_back(b);
    if (samp.size() > 16) void'(samp.pop_front());
    for (int k = 0; k < 4; k++) begin
      exp_m[k] = 1'b0;
      since[k]++;
      if (since[k] >= 4 && model_hist() == pat[k]) begin
        exp_m[k] = 1'b1;
        nmatch[k]++;
        if (!ov[k]) since[k] = 0;
      end
    end
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (h[k] !== model_hist()) begin
        errors++;
        $display("FAIL %s hist[%0d] got %b want %b", tag, k, h[k], model_hist());
      end
      checks++;
      if (c[k] !== model_count(k)) begin
        errors++;
        $display("FAIL %s count[%0d] got %0d want %0d", tag, k, c[k], model_count(k));
      end
    end
  endtask

  // One button press; clr_hit raises clr exactly in the cycle the sample lands.
  task automatic press(input bit b, input int hold, input bit clr_hit);
    @(negedge clk);
    sw = b;
    button = 1'b1;
    if (clr_hit) model_clear();
    else model_sample(b);
    for (int i = 1; i <= hold + 4; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (m[k] !== ((i == 3) ? exp_m[k] : 1'b0)) begin
          errors++;
          $display("FAIL match[%0d] cyc %0d got %b want %b", k, i, m[k],
                   (i == 3) ? exp_m[k] : 1'b0);
        end
      end
      if (i == 3) check_state("press");
      if (i == hold + 4) check_state("press_end");
      if (i == hold) button = 1'b0;
      if (clr_hit && i == 2) clr = 1'b1;
      if (clr_hit && i == 3) clr = 1'b0;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    check_state("clear");
  endtask

  task automatic check_display(input string tag);
    logic [3:0] want;
    logic [3:0] hm;
    hm = model_hist();
    repeat (26) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (an[k] < 3'd4) want = {3'b000, hm[an[k][1:0]]};
        else if (an[k] == 3'd4) want = model_fill_digit(k);
        else want = model_count(k);
        checks++;
        if (an[k] > 3'd5 || d[k] !== want) begin
          errors++;
          $display("FAIL %s disp[%0d] AN=%0d got D=%h want %h", tag, k, an[k], d[k], want);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    model_clear();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (m[k] !== 1'b0 || d[k] !== 4'h0 || an[k] !== 3'd0) begin
        errors++;
        $display("FAIL reset[%0d] got m=%b D=%h AN=%0d want 0 0 0", k, m[k], d[k], an[k]);
      end
    end
    check_state("reset");
    rst = 1'b0;
    for (int i = 1; i <= 28; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (an[k] !== 3'((i / 4) % 6) || d[k] !== (((i / 4) % 6 == 4) ? 4'hA : 4'h0)
            || m[k] !== 1'b0) begin
          errors++;
          $display("FAIL scan_idle[%0d] cyc %0d got AN=%0d D=%h m=%b want AN=%0d", k, i,
                   an[k], d[k], m[k], (i / 4) % 6);
        end
      end
    end
  endtask

  task automatic test_basic();
    press(1, 2, 0); press(1, 2, 0); press(0, 2, 0); press(0, 2, 0);
    check_display("basic");
  endtask

  task automatic test_overlap();
    do_clear();
    for (int n = 0; n < 6; n++) press(bit'((n + 1) % 2), 2, 0);
    check_display("overlap");
  endtask

  task automatic test_hold();
    do_clear();
    press(1, 50, 0); press(0, 50, 0); press(1, 50, 0); press(1, 1, 0);
  endtask

  task automatic test_saturate();
    do_clear();
    repeat (5) begin
      press(1, 1, 0); press(1, 1, 0); press(0, 1, 0); press(0, 1, 0);
    end
    check_display("saturate");
  endtask

  task automatic test_clr_collision();
    do_clear();
    press(1, 2, 0); press(1, 2, 0); press(0, 2, 0);
    press(0, 2, 1);
    check_display("clr_hit");
    press(1, 2, 0); press(1, 2, 0); press(0, 2, 0); press(0, 2, 0);
    check_state("after_clr");
  endtask

  task automatic test_random();
    do_clear();
    repeat (60) begin
      press(bit'($urandom % 2), 1 + int'($urandom % 4), ($urandom % 10) == 0);
    end
    check_display("random");
  endtask

  initial begin
    pat  = '{4'b1100, 4'b1010, 4'b1010, 4'b1100};
    ov   = '{1'b1, 1'b1, 1'b0, 1'b1};
    cmax = '{15, 15, 15, 3};
    model_clear();
    test_reset();
    test_basic();
    test_overlap();
    test_hold();
    test_saturate();
    test_clr_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
